// File: rtl/alu_pipe_pkg.sv
// Shared types and helpers for the alu_pipe datapath slice.
package alu_pipe_package;

   localparam int unsigned DEF_WIDTH = 8;

   typedef enum logic [2:0] {
      OP_RST = 3'd0,
      OP_MOV = 3'd1,
      OP_NOT = 3'd2,
      OP_ADD = 3'd3,
      OP_AND = 3'd4,
      OP_XOR = 3'd5,
      OP_LSH = 3'd6,
      OP_RSH = 3'd7
   } alu_op_t;

   // Number of operand-B bits used as the shift amount.
   function automatic int unsigned shw(input int unsigned width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational ALU for stage 2 of alu_pipe.
// Build option: define ALU_SAT_EN to make ADD saturate to all-ones on overflow.
module alu_pipe_core
   import alu_pipe_package::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  alu_op_t          i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_result,
   output logic             o_carry,
   output logic             o_zero
);

   localparam int unsigned SHW = shw(WIDTH);

   logic [SHW-1:0] w_n;
   logic [WIDTH:0] w_sum;
   logic [WIDTH:0] w_lsh;
   logic [WIDTH:0] w_rsh;

   assign w_n = i_b[SHW-1:0];

   // Widened shifts: the extra bit catches the last bit shifted out (0 when n=0).
   always_comb begin
      w_sum = {1'b0, i_a} + {1'b0, i_b};
      w_lsh = {1'b0, i_a} << w_n;
      w_rsh = {i_a, 1'b0} >> w_n;
   end

   // Opcode decode into result and carry.
   always_comb begin
      o_result = '0;
      o_carry  = 1'b0;
      unique case (i_op)
         OP_RST: o_result = '0;
         OP_MOV: o_result = i_a;
         OP_NOT: o_result = ~i_a;
         OP_ADD: begin
            o_carry = w_sum[WIDTH];
`ifdef ALU_SAT_EN
            o_result = w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0];
`else
            o_result = w_sum[WIDTH-1:0];
`endif
         end
         OP_AND: o_result = i_a & i_b;
         OP_XOR: o_result = i_a ^ i_b;
         OP_LSH: begin
            o_result = w_lsh[WIDTH-1:0];
            o_carry  = w_lsh[WIDTH];
         end
         OP_RSH: begin
            o_result = w_rsh[WIDTH:1];
            o_carry  = w_rsh[0];
         end
         default: begin
            o_result = '0;
            o_carry  = 1'b0;
         end
      endcase
   end

   assign o_zero = (o_result == '0);

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready backpressure on both sides.
// Build option: ALU_SAT_EN (handled inside alu_pipe_core).
module alu_pipe
   import alu_pipe_package::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned TAG_W = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  alu_op_t          opcode,
   input  logic [WIDTH-1:0] data_1,
   input  logic [WIDTH-1:0] data_2,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] alu_out,
   output logic             carry,
   output logic             zero,
   output logic [TAG_W-1:0] out_tag,
   output logic [CNT_W-1:0] txn_count
);

   logic             r_s1_valid;
   alu_op_t          r_s1_op;
   logic [WIDTH-1:0] r_s1_a;
   logic [WIDTH-1:0] r_s1_b;
   logic [TAG_W-1:0] r_s1_tag;

   logic             r_s2_valid;
   logic [WIDTH-1:0] r_alu_out;
   logic             r_carry;
   logic             r_zero;
   logic [TAG_W-1:0] r_out_tag;
   logic [CNT_W-1:0] r_txn_count;

   logic             w_s1_adv;
   logic             w_s2_adv;
   logic [WIDTH-1:0] w_result;
   logic             w_carry;
   logic             w_zero;

   assign w_s2_adv  = !r_s2_valid || out_ready;
   assign w_s1_adv  = !r_s1_valid || w_s2_adv;
   assign in_ready  = w_s1_adv;
   assign out_valid = r_s2_valid;
   assign alu_out   = r_alu_out;
   assign carry     = r_carry;
   assign zero      = r_zero;
   assign out_tag   = r_out_tag;
   assign txn_count = r_txn_count;

   alu_pipe_core #(.WIDTH(WIDTH)) u_core (
      .i_op     (r_s1_op),
      .i_a      (r_s1_a),
      .i_b      (r_s1_b),
      .o_result (w_result),
      .o_carry  (w_carry),
      .o_zero   (w_zero)
   );

   // Stage 1: capture the request on accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_op    <= OP_RST;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_tag   <= '0;
      end else if (w_s1_adv) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_op  <= opcode;
            r_s1_a   <= data_1;
            r_s1_b   <= data_2;
            r_s1_tag <= in_tag;
         end
      end
   end

   // Stage 2: register the ALU result, flags and tag; hold while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_alu_out  <= '0;
         r_carry    <= 1'b0;
         r_zero     <= 1'b0;
         r_out_tag  <= '0;
      end else if (w_s2_adv) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_alu_out <= w_result;
            r_carry   <= w_carry;
            r_zero    <= w_zero;
            r_out_tag <= r_s1_tag;
         end
      end
   end

   // Count results accepted by the consumer; wraps naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_txn_count <= '0;
      end else if (r_s2_valid && out_ready) begin
         r_txn_count <= r_txn_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (WIDTH=8 and WIDTH=16 instances).
module tb_alu_pipe;
   import alu_pipe_package::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   always #5 clk = ~clk;

   // 8-bit instance signals
   logic        in_valid  = 1'b0;
   logic        in_ready;
   alu_op_t     opcode    = OP_RST;
   logic [7:0]  data_1    = '0;
   logic [7:0]  data_2    = '0;
   logic [3:0]  in_tag    = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [7:0]  alu_out;
   logic        carry;
   logic        zero;
   logic [3:0]  out_tag;
   logic [15:0] txn_count;

   // 16-bit instance signals
   logic        w_in_valid  = 1'b0;
   logic        w_in_ready;
   alu_op_t     w_opcode    = OP_RST;
   logic [15:0] w_data_1    = '0;
   logic [15:0] w_data_2    = '0;
   logic [3:0]  w_in_tag    = '0;
   logic        w_out_valid;
   logic        w_out_ready = 1'b1;
   logic [15:0] w_alu_out;
   logic        w_carry;
   logic        w_zero;
   logic [3:0]  w_out_tag;
   logic [15:0] w_txn_count;

   alu_pipe #(.WIDTH(8), .TAG_W(4), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .data_1(data_1), .data_2(data_2), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .alu_out(alu_out),
      .carry(carry), .zero(zero), .out_tag(out_tag), .txn_count(txn_count)
   );

   alu_pipe #(.WIDTH(16), .TAG_W(4), .CNT_W(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
      .opcode(w_opcode), .data_1(w_data_1), .data_2(w_data_2), .in_tag(w_in_tag),
      .out_valid(w_out_valid), .out_ready(w_out_ready), .alu_out(w_alu_out),
      .carry(w_carry), .zero(w_zero), .out_tag(w_out_tag), .txn_count(w_txn_count)
   );

   int total = 0;
   int bad   = 0;
   int exp_cnt = 0;

   typedef struct packed {
      logic [7:0] r;
      logic       c;
      logic       z;
      logic [3:0] t;
   } exp_t;

   exp_t q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Bit-serial reference model; returns {carry, result}.
   function automatic logic [8:0] ref_alu(input alu_op_t op, input logic [7:0] a, input logic [7:0] b);
      logic [8:0] s;
      logic [7:0] r;
      logic       c;
      r = 8'h00;
      c = 1'b0;
      case (op)
         OP_MOV: r = a;
         OP_NOT: r = ~a;
         OP_ADD: begin
            s = {1'b0, a} + {1'b0, b};
            c = s[8];
            r = s[7:0];
`ifdef ALU_SAT_EN
            if (c) r = 8'hFF;
`endif
         end
         OP_AND: r = a & b;
         OP_XOR: r = a ^ b;
         OP_LSH: begin
            r = a;
            for (int i = 0; i < int'(b[2:0]); i++) begin
               c = r[7];
               r = {r[6:0], 1'b0};
            end
         end
         OP_RSH: begin
            r = a;
            for (int i = 0; i < int'(b[2:0]); i++) begin
               c = r[0];
               r = {1'b0, r[7:1]};
            end
         end
         default: r = 8'h00;
      endcase
      return {c, r};
   endfunction

   // One operation through the 8-bit pipe with out_ready held high.
   task automatic op8(input string nm, input alu_op_t op, input logic [7:0] a, input logic [7:0] b,
                      input logic [3:0] tag, input logic [7:0] er, input logic ec, input logic ez);
      @(negedge clk);
      chk({nm, "_cnt_before"}, txn_count, exp_cnt);
      in_valid = 1'b1; opcode = op; data_1 = a; data_2 = b; in_tag = tag; out_ready = 1'b1;
      #1 chk({nm, "_in_ready"}, in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      chk({nm, "_lat1_valid"}, out_valid, 0);
      @(negedge clk);
      chk({nm, "_valid"}, out_valid, 1);
      chk({nm, "_result"}, alu_out, er);
      chk({nm, "_carry"}, carry, ec);
      chk({nm, "_zero"}, zero, ez);
      chk({nm, "_tag"}, out_tag, tag);
      exp_cnt++;
   endtask

   // One operation through the 16-bit pipe with out_ready held high.
   task automatic op16(input string nm, input alu_op_t op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] er, input logic ec, input logic ez);
      @(negedge clk);
      w_in_valid = 1'b1; w_opcode = op; w_data_1 = a; w_data_2 = b; w_in_tag = 4'h9;
      @(negedge clk);
      w_in_valid = 1'b0;
      @(negedge clk);
      chk({nm, "_valid"}, w_out_valid, 1);
      chk({nm, "_result"}, w_alu_out, er);
      chk({nm, "_carry"}, w_carry, ec);
      chk({nm, "_zero"}, w_zero, ez);
      chk({nm, "_tag"}, w_out_tag, 4'h9);
   endtask

   initial begin
      alu_op_t    p_op;
      logic [7:0] p_a, p_b;
      logic [8:0] m;
      exp_t       e;
      bit         need;
      bit         tog;
      int         sent, got, cyc;

      // Reset state
      #2 rst_n = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_alu_out", alu_out, 0);
      chk("rst_carry", carry, 0);
      chk("rst_zero", zero, 0);
      chk("rst_out_tag", out_tag, 0);
      chk("rst_txn_count", txn_count, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_in_ready", in_ready, 1);

      // Directed single operations
`ifdef ALU_SAT_EN
      op8("add_ovf", OP_ADD, 8'hF0, 8'h20, 4'h5, 8'hFF, 1'b1, 1'b0);
`else
      op8("add_ovf", OP_ADD, 8'hF0, 8'h20, 4'h5, 8'h10, 1'b1, 1'b0);
`endif
      op8("add_noovf", OP_ADD, 8'h12, 8'h34, 4'h6, 8'h46, 1'b0, 1'b0);
      op8("lsh_81_1", OP_LSH, 8'h81, 8'h01, 4'h7, 8'h02, 1'b1, 1'b0);
      op8("rsh_01_1", OP_RSH, 8'h01, 8'h01, 4'h8, 8'h00, 1'b1, 1'b1);
      op8("lsh_5a_0", OP_LSH, 8'h5A, 8'h00, 4'h9, 8'h5A, 1'b0, 1'b0);
      op8("rsh_5a_0", OP_RSH, 8'h5A, 8'h00, 4'hA, 8'h5A, 1'b0, 1'b0);
      op8("lsh_5a_7", OP_LSH, 8'h5B, 8'h07, 4'hB, 8'h80, 1'b1, 1'b0);
      op8("rst_op", OP_RST, 8'hFF, 8'hFF, 4'hC, 8'h00, 1'b0, 1'b1);
      op8("not_op", OP_NOT, 8'h0F, 8'h00, 4'hD, 8'hF0, 1'b0, 1'b0);
      op8("and_op", OP_AND, 8'hCC, 8'hAA, 4'hE, 8'h88, 1'b0, 1'b0);
      op8("xor_op", OP_XOR, 8'hCC, 8'hCC, 4'hF, 8'h00, 1'b0, 1'b1);
      op8("mov_op", OP_MOV, 8'hA5, 8'h3C, 4'h0, 8'hA5, 1'b0, 1'b0);

      // Backpressure: tags 1..4 with out_ready low, then released
      @(negedge clk);
      chk("bp_cnt_start", txn_count, exp_cnt);
      out_ready = 1'b0;
      in_valid = 1'b1; opcode = OP_MOV; data_1 = 8'h01; data_2 = 8'h00; in_tag = 4'h1;
      #1 chk("bp_rdy_t1", in_ready, 1);
      @(negedge clk);
      data_1 = 8'h02; in_tag = 4'h2;
      #1 chk("bp_rdy_t2", in_ready, 1);
      @(negedge clk);
      data_1 = 8'h03; in_tag = 4'h3;
      #1 chk("bp_rdy_t3_blocked", in_ready, 0);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_tag_a", out_tag, 4'h1);
      @(negedge clk);
      chk("bp_hold_tag_b", out_tag, 4'h1);
      chk("bp_hold_res_b", alu_out, 8'h01);
      #1 chk("bp_rdy_still_low", in_ready, 0);
      out_ready = 1'b1;
      #1 chk("bp_rdy_comb", in_ready, 1);
      @(negedge clk);
      chk("bp_out_tag2", out_tag, 4'h2);
      chk("bp_out_res2", alu_out, 8'h02);
      data_1 = 8'h04; in_tag = 4'h4;
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp_out_tag3", out_tag, 4'h3);
      chk("bp_out_res3", alu_out, 8'h03);
      @(negedge clk);
      chk("bp_out_valid4", out_valid, 1);
      chk("bp_out_tag4", out_tag, 4'h4);
      @(negedge clk);
      exp_cnt += 4;
      chk("bp_drained", out_valid, 0);
      chk("bp_txn_count", txn_count, exp_cnt);

      // Alternating out_ready with 20 random ops against the reference model
      sent = 0; got = 0; cyc = 0; need = 1'b1; tog = 1'b0;
      p_op = OP_RST; p_a = '0; p_b = '0;
      while (got < 20 && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (need && sent < 20) begin
            p_op = alu_op_t'($urandom_range(0, 7));
            p_a  = 8'($urandom);
            p_b  = 8'($urandom);
            need = 1'b0;
         end
         tog = !tog;
         out_ready = tog;
         in_valid = (sent < 20);
         opcode = p_op; data_1 = p_a; data_2 = p_b; in_tag = 4'(sent);
         #1;
         if (out_valid && out_ready) begin
            chk("rnd_nonempty", (q.size() > 0), 1);
            if (q.size() > 0) begin
               e = q.pop_front();
               chk("rnd_result", alu_out, e.r);
               chk("rnd_carry", carry, e.c);
               chk("rnd_zero", zero, e.z);
               chk("rnd_tag", out_tag, e.t);
            end
            got++;
            exp_cnt++;
         end
         if (in_valid && in_ready) begin
            m = ref_alu(p_op, p_a, p_b);
            q.push_back('{r: m[7:0], c: m[8], z: (m[7:0] == 8'h00), t: 4'(sent)});
            sent++;
            need = 1'b1;
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("rnd_got", got, 20);
      chk("rnd_sent", sent, 20);
      @(negedge clk);
      chk("rnd_queue_empty", q.size(), 0);
      chk("rnd_no_extra", out_valid, 0);
      chk("rnd_txn_count", txn_count, exp_cnt);

      // Reset with two ops in flight
      out_ready = 1'b0;
      in_valid = 1'b1; opcode = OP_MOV; data_1 = 8'h77; in_tag = 4'hA;
      @(negedge clk);
      data_1 = 8'h88; in_tag = 4'hB;
      @(negedge clk);
      in_valid = 1'b0;
      chk("mid_pre_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_count", txn_count, 0);
      exp_cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("mid_no_output", out_valid, 0);
      end
      chk("mid_txn_count", txn_count, exp_cnt);

      // WIDTH=16 instance
`ifdef ALU_SAT_EN
      op16("w16_add", OP_ADD, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b1, 1'b0);
`else
      op16("w16_add", OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1);
`endif
      op16("w16_rsh", OP_RSH, 16'h8000, 16'h000F, 16'h0001, 1'b0, 1'b0);
      op16("w16_lsh", OP_LSH, 16'h4001, 16'h0002, 16'h0004, 1'b1, 1'b0);
      @(negedge clk);
      chk("w16_txn_count", w_txn_count, 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined successor of the single-cycle 8-bit lab ALU.
- Adds generic data width, a variable shift amount, carry/zero flags, and a transaction tag.
- Uses valid/ready handshakes with full backpressure on both input and output.
- Sits between the instruction generator/sequencer and the result checker in the lab datapath.

Parameters:
- WIDTH, 8: operand and result width in bits; minimum 2.
- TAG_W, 4: width of the opaque transaction tag carried alongside each operation.
- CNT_W, 16: width of the completed-transaction counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request this cycle.
- opcode  in  3  operation; type alu_pipe_package::alu_op_t.
- data_1  in  WIDTH  operand A.
- data_2  in  WIDTH  operand B; low SHW=$clog2(WIDTH) bits give the shift amount for LSH/RSH.
- in_tag  in  TAG_W  request tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- alu_out  out  WIDTH  result.
- carry  out  1  carry/shift-out flag.
- zero  out  1  result equals zero.
- out_tag  out  TAG_W  tag of the presented result.
- txn_count  out  CNT_W  number of results accepted at the output.

Behaviour:
- Reset: asynchronous and active-low. Clears s1_valid, s2_valid, alu_out, carry, zero, out_tag and txn_count to 0. out_valid=0. in_ready=1 one cycle after rst_n deasserts.
- Reset mid-operation: all in-flight operations are discarded, with no output.
- Stage 1 registers opcode, operands and tag on input accept (in_valid && in_ready).
- Stage 2 computes the result and registers it together with the flags and tag.
- Latency: 2 cycles from accept to out_valid when out_ready is held high. Throughput is 1 op/cycle.
- Handshake:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv. This is combinational from out_ready; no other input-to-output combinational path exists.
  - While out_valid && !out_ready, alu_out, flags and out_tag hold stable.
  - Results emerge in acceptance order.
  - Accept and output on the same cycle are allowed.
- Operations (WIDTH-bit, unsigned, result wraps modulo 2^WIDTH):
  - RST=0: result 0, carry 0.
  - MOV=1: result A, carry 0.
  - NOT=2: result ~A, carry 0.
  - ADD=3: result A+B; carry = bit WIDTH of the (WIDTH+1)-bit sum.
  - AND=4: result A&B, carry 0.
  - XOR=5: result A^B, carry 0.
  - LSH=6: result A<<n with n = B[SHW-1:0]. carry = last bit shifted out, i.e. A[WIDTH-n]. n=0 gives result A, carry 0.
  - RSH=7: result A>>n (logical). carry = A[n-1]. n=0 gives result A, carry 0.
- zero = (result == 0) for every opcode, including RST.
- txn_count increments on each out_valid && out_ready and wraps from all-ones to 0.
- RST opcode only zeroes the result; it does not flush the pipeline.

Optional Feature:
- Macro: ALU_SAT_EN.
- Defined: ADD saturates to all-ones on overflow, with carry still reporting overflow. Example: F0+20 gives FF, carry=1.
- Undefined: ADD wraps. Example: F0+20 gives 10, carry=1.
- All other opcodes are unaffected in both cases.

Decomposition:
- Package alu_pipe_package:
  - alu_op_t: 3-bit enum with the encodings above.
  - Constant DEF_WIDTH=8.
  - Function shw(width) returning $clog2(width).
- Sub-module alu_pipe_core: purely combinational. Takes opcode, A, B and returns result, carry and zero. Instantiated in stage 2. The ALU_SAT_EN branch lives here.
- Top level holds the pipeline registers, handshake logic and counter.

Test Plan (WIDTH=8 unless noted):
- ADD F0,20, out_ready=1 → out_valid 2 cycles after accept, alu_out=10, carry=1, zero=0, out_tag=in_tag. With ALU_SAT_EN → alu_out=FF, carry=1.
- LSH 81,B=01 → 02, carry=1. RSH 01,B=01 → 00, carry=1, zero=1. LSH 5A,B=00 → 5A, carry=0.
- Back-to-back tags 1,2,3,4 with out_ready=0 → in_ready falls after tags 1,2 are accepted. out_tag holds 1 stably. Releasing out_ready delivers 1,2,3,4 in order, one per cycle. txn_count=4.
- Alternate out_ready 1/0 every cycle while in_valid=1 → no loss or duplication of 20 random ops; each result matches the reference model.
- rst_n low for 1 cycle while 2 ops are in flight → out_valid=0 and txn_count=0 immediately. Neither op appears after release.
- WIDTH=16, ADD FFFF+0001 → 0000, carry=1, zero=1. RSH 8000,B=000F → 0001, carry=0.
